// File: rtl/fir_cascade_scheduler.sv
// Time-shares one FIR MAC engine across a cascade of decimation stages.
// Each stage owns one pending sample slot; the deepest pending stage is served first.
module fir_cascade_scheduler #(
    parameter int NUM_STAGES = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEC_FACTOR = 2,
    parameter int STAGE_W    = $clog2(NUM_STAGES)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid_in,
    output logic                  eng_start_out,
    output logic [STAGE_W-1:0]    eng_stage_out,
    output logic [DATA_WIDTH-1:0] eng_sample_out,
    output logic                  eng_decimate_out,
    input  logic                  eng_done_in,
    input  logic [DATA_WIDTH-1:0] eng_result_in,
    output logic [DATA_WIDTH-1:0] audio_out,
    output logic                  audio_valid_out,
    output logic [NUM_STAGES-1:0] overrun_out,
    output logic                  busy_out
);

    localparam int PH_W = (DEC_FACTOR > 1) ? $clog2(DEC_FACTOR) : 1;
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
    localparam logic [PH_W-1:0]    PH_LAST    = PH_W'(DEC_FACTOR - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t                  state;
    logic [NUM_STAGES-1:0]   pend;
    logic [DATA_WIDTH-1:0]   slot  [NUM_STAGES];
    logic [PH_W-1:0]         phase [NUM_STAGES];
    logic [STAGE_W-1:0]      sel;
    logic                    dec_q;

    logic                    any_pend;
    logic [STAGE_W-1:0]      pick_idx;
    logic                    dec_now;
    logic                    route_en;
    logic [NUM_STAGES-1:0]   wr_en;
    logic [NUM_STAGES-1:0]   clr;
    logic [DATA_WIDTH-1:0]   wr_data [NUM_STAGES];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pick_idx = '0;
        any_pend = |pend;
        // Ascending scan: the last hit is the highest-index (deepest) pending stage.
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (pend[k]) pick_idx = STAGE_W'(k);
        end
    end

    assign dec_now  = (phase[sel] == PH_LAST);
    assign route_en = (state == ST_WAIT) && eng_done_in && dec_q;

    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            wr_en[k]   = 1'b0;
            wr_data[k] = eng_result_in;
            clr[k]     = (state == ST_ISSUE) && (sel == STAGE_W'(k));
        end
        wr_en[0]   = sample_valid_in;
        wr_data[0] = sample_in;
        for (int k = 1; k < NUM_STAGES; k++) begin
            wr_en[k] = route_en && (sel == STAGE_W'(k - 1));
        end
    end

    // Engine data reflects the slot as it stands in the ISSUE cycle itself.
    assign eng_sample_out   = eng_start_out ? slot[sel] : '0;
    assign eng_decimate_out = eng_start_out & dec_now;
    assign busy_out         = (state != ST_IDLE);

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= ST_IDLE;
            pend            <= '0;
            overrun_out     <= '0;
            sel             <= '0;
            dec_q           <= 1'b0;
            eng_start_out   <= 1'b0;
            eng_stage_out   <= '0;
            audio_out       <= '0;
            audio_valid_out <= 1'b0;
            // NOTE: the slot and phase arrays are reset too, so no stale sample survives a restart.
            for (int k = 0; k < NUM_STAGES; k++) begin
                slot[k]  <= '0;
                phase[k] <= '0;
            end
        end else begin
            eng_start_out   <= 1'b0;
            audio_valid_out <= 1'b0;

            // A write in the ISSUE cycle of the same slot wins over the clear and is not an overrun.
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (wr_en[k]) begin
                    slot[k] <= wr_data[k];
                    pend[k] <= 1'b1;
                    if (pend[k] && !clr[k]) overrun_out[k] <= 1'b1;
                end else if (clr[k]) begin
                    pend[k] <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (any_pend) begin
                        sel           <= pick_idx;
                        eng_stage_out <= pick_idx;
                        eng_start_out <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    dec_q      <= dec_now;
                    phase[sel] <= phase[sel] + PH_W'(1);
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done_in) begin
                        if (dec_q && (sel == LAST_STAGE)) begin
                            audio_out       <= eng_result_in;
                            audio_valid_out <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_cascade_scheduler.sv
// Scoreboard bench for fir_cascade_scheduler: expected engine commands and audio
// outputs are queued by the stimulus and checked by an independent monitor.
module tb_fir_cascade_scheduler;

    localparam int NS = 4;
    localparam int DW = 16;
    localparam int SW = 2;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid_in = 1'b0;
    logic          eng_start_out;
    logic [SW-1:0] eng_stage_out;
    logic [DW-1:0] eng_sample_out;
    logic          eng_decimate_out;
    logic          eng_done_in = 1'b0;
    logic [DW-1:0] eng_result_in = '0;
    logic [DW-1:0] audio_out;
    logic          audio_valid_out;
    logic [NS-1:0] overrun_out;
    logic          busy_out;

    fir_cascade_scheduler #(
        .NUM_STAGES(NS), .DATA_WIDTH(DW), .DEC_FACTOR(2)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .sample_in(sample_in), .sample_valid_in(sample_valid_in),
        .eng_start_out(eng_start_out), .eng_stage_out(eng_stage_out),
        .eng_sample_out(eng_sample_out), .eng_decimate_out(eng_decimate_out),
        .eng_done_in(eng_done_in), .eng_result_in(eng_result_in),
        .audio_out(audio_out), .audio_valid_out(audio_valid_out),
        .overrun_out(overrun_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int stage;
        int sample;
        bit dec;
        int at_cyc;
    } issue_t;

    issue_t exp_issue[$];
    int     exp_audio[$];
    int     checks   = 0;
    int     failures = 0;
    bit     chk_issue = 1'b1;
    int     n_issue  = 0;
    int     n_dec    = 0;
    int     last_done = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        failures++;
        $display("FAIL %s: unexpected DUT event at cycle %0d", name, cyc);
    endtask

    function automatic void push_issue(input int st, input int smp, input bit d, input int c = -1);
        issue_t it;
        it.stage = st; it.sample = smp; it.dec = d; it.at_cyc = c;
        exp_issue.push_back(it);
    endfunction

    // Engine model: result = sample + 1, done exactly 10 cycles after the start cycle.
    initial begin
        logic [DW-1:0] res;
        forever begin
            @(negedge clk_in);
            if (eng_start_out && !rst_in) begin
                res = eng_sample_out + 16'd1;
                repeat (10) @(posedge clk_in);
                #1 eng_done_in = 1'b1; eng_result_in = res;
                @(posedge clk_in);
                #1 eng_done_in = 1'b0; eng_result_in = '0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a command or audio sample.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (eng_done_in) last_done = cyc;
            if (eng_start_out) begin
                n_issue++;
                if (eng_decimate_out) n_dec++;
                if (chk_issue) begin
                    if (exp_issue.size() == 0) fail_event("unexpected_issue");
                    else begin
                        issue_t it;
                        it = exp_issue.pop_front();
                        check("issue_stage", 32'(eng_stage_out), 32'(it.stage));
                        check("issue_sample", 32'(eng_sample_out), 32'(it.sample));
                        check("issue_decimate", 32'(eng_decimate_out), 32'(it.dec));
                        if (it.at_cyc >= 0) check("issue_latency", 32'(cyc), 32'(it.at_cyc));
                    end
                end
            end
            if (audio_valid_out) begin
                if (exp_audio.size() == 0) fail_event("unexpected_audio");
                else check("audio_value", 32'(audio_out), 32'(exp_audio.pop_front()));
                check("audio_latency", 32'(cyc), 32'(last_done + 1));
            end
        end
    end

    task automatic do_reset();
        #1 rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
    endtask

    // Called just after a rising edge (cycle c); returns just after the next one.
    task automatic pulse(input logic [DW-1:0] v);
        sample_in = v;
        sample_valid_in = 1'b1;
        @(posedge clk_in);
        #1 sample_valid_in = 1'b0;
        sample_in = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic drained(input string tag);
        check({tag, "_issue_q_empty"}, 32'(exp_issue.size()), 32'd0);
        check({tag, "_audio_q_empty"}, 32'(exp_audio.size()), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy_out), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_start"}, 32'(eng_start_out), 32'd0);
        check({tag, "_stage"}, 32'(eng_stage_out), 32'd0);
        check({tag, "_sample"}, 32'(eng_sample_out), 32'd0);
        check({tag, "_decimate"}, 32'(eng_decimate_out), 32'd0);
        check({tag, "_audio"}, 32'(audio_out), 32'd0);
        check({tag, "_audio_valid"}, 32'(audio_valid_out), 32'd0);
        check({tag, "_overrun"}, 32'(overrun_out), 32'd0);
        check({tag, "_busy"}, 32'(busy_out), 32'd0);
    endtask

    initial begin
        int t;
        int base_issue;
        int base_dec;

        // Reset state
        do_reset();
        check_cleared("reset");

        // Single sample: issue two cycles later, shift only, nothing further
        t = cyc;
        push_issue(0, 16'h0100, 1'b0, t + 2);
        pulse(16'h0100);
        idle(30);
        drained("single");

        // Two samples 40 cycles apart: second decimates and feeds stage 1
        do_reset();
        push_issue(0, 16'h0010, 1'b0);
        pulse(16'h0010);
        idle(39);
        push_issue(0, 16'h0020, 1'b1);
        push_issue(1, 16'h0021, 1'b0);
        pulse(16'h0020);
        idle(40);
        drained("two");

        // Full cascade: 16 zeros give one audio sample of 4
        do_reset();
        chk_issue = 1'b0;
        base_issue = n_issue;
        base_dec = n_dec;
        exp_audio.push_back(16'h0004);
        for (int i = 0; i < 16; i++) begin
            pulse(16'h0000);
            idle(99);
        end
        idle(20);
        check("cascade_issue_count", 32'(n_issue - base_issue), 32'd30);
        check("cascade_decimate_count", 32'(n_dec - base_dec), 32'd15);
        check("cascade_overrun", 32'(overrun_out), 32'd0);
        check("cascade_audio_hold", 32'(audio_out), 32'h0004);
        drained("cascade");
        chk_issue = 1'b1;

        // Priority: stages 0 and 2 pending together, stage 2 goes first
        do_reset();
        push_issue(0, 1, 1'b0);
        pulse(16'd1); idle(39);
        push_issue(0, 2, 1'b1);
        push_issue(1, 3, 1'b0);
        pulse(16'd2); idle(39);
        push_issue(0, 3, 1'b0);
        pulse(16'd3); idle(39);
        push_issue(0, 4, 1'b1);
        push_issue(1, 5, 1'b1);
        push_issue(2, 6, 1'b0);
        push_issue(0, 5, 1'b0);
        pulse(16'd4); idle(17);
        pulse(16'd5);
        idle(50);
        check("priority_overrun", 32'(overrun_out), 32'd0);
        drained("priority");

        // Overrun: two writes while stage 0 is in WAIT
        do_reset();
        push_issue(0, 16'h0A00, 1'b0);
        push_issue(0, 16'h0C00, 1'b1);
        push_issue(1, 16'h0C01, 1'b0);
        pulse(16'h0A00);
        idle(4);
        pulse(16'h0B00);
        idle(2);
        pulse(16'h0C00);
        idle(50);
        check("overrun_set", 32'(overrun_out), 32'b0001);
        drained("overrun");

        // Write in the exact ISSUE cycle of stage 0 is not an overrun
        do_reset();
        t = cyc;
        push_issue(0, 16'h0123, 1'b0, t + 2);
        push_issue(0, 16'h0456, 1'b1);
        push_issue(1, 16'h0457, 1'b0);
        pulse(16'h0123);
        idle(1);
        pulse(16'h0456);
        idle(50);
        check("issue_cycle_write_overrun", 32'(overrun_out), 32'd0);
        drained("issue_cycle");

        // Reset mid-WAIT, then a stale done arrives and must be ignored
        do_reset();
        t = cyc;
        push_issue(0, 16'h0077, 1'b0, t + 2);
        pulse(16'h0077);
        idle(5);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        check_cleared("mid_reset");
        idle(20);
        check("stale_done_audio", 32'(audio_valid_out), 32'd0);
        drained("stale_done");
        t = cyc;
        push_issue(0, 16'h0099, 1'b0, t + 2);
        pulse(16'h0099);
        idle(20);
        drained("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
